// File: rtl/key_debounce_if.sv
// Raw key inputs and debounced level/strobe outputs.
// The master side models the buttons; the debouncer is the slave.
interface key_debounce_if #(
  parameter int CH = 2
);
  logic [CH-1:0] key_in;
  logic [CH-1:0] key_level;
  logic [CH-1:0] key_press;
  logic [CH-1:0] key_release;

  modport master (
    output key_in,
    input  key_level,
    input  key_press,
    input  key_release
  );

  modport slave (
    input  key_in,
    output key_level,
    output key_press,
    output key_release
  );
endinterface

// File: rtl/key_debounce.sv
// Per-channel two-flop synchronizer and four-state debounce FSM.
// Emits a registered level plus one-cycle press/release strobes.
module key_debounce #(
  parameter int CH            = 2,
  parameter int DB_CYCLES     = 1000000,
  parameter bit ACTIVE_LOW_IN = 1'b1
) (
  input  logic           clk,
  input  logic           reset_n,
  key_debounce_if.slave  kif
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  localparam logic [23:0]   DB   = 24'(DB_CYCLES);
  localparam logic [CH-1:0] IDLE = {CH{ACTIVE_LOW_IN}};

  logic [CH-1:0] s1_q;
  logic [CH-1:0] s2_q;
  logic [CH-1:0] pressed_s;

  // Reset to the released level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q <= IDLE;
      s2_q <= IDLE;
    end else begin
      s1_q <= kif.key_in;
      s2_q <= s1_q;
    end
  end

  assign pressed_s = s2_q ^ IDLE;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_e      state_q;
    logic [23:0] cnt_q;
    logic        lvl_q;
    logic        prs_q;
    logic        rel_q;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        state_q <= RELEASED;
        cnt_q   <= '0;
        lvl_q   <= 1'b0;
        prs_q   <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        prs_q <= 1'b0;
        rel_q <= 1'b0;
        unique case (state_q)
          RELEASED: begin
            if (pressed_s[i]) begin
              state_q <= PRESS_WAIT;
              cnt_q   <= 24'd1;
            end
          end
          PRESS_WAIT: begin
            if (!pressed_s[i]) begin
              state_q <= RELEASED;
              cnt_q   <= '0;
            end else if (cnt_q == DB) begin
              state_q <= PRESSED;
              lvl_q   <= 1'b1;
              prs_q   <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 24'd1;
            end
          end
          PRESSED: begin
            if (!pressed_s[i]) begin
              state_q <= RELEASE_WAIT;
              cnt_q   <= 24'd1;
            end
          end
          RELEASE_WAIT: begin
            if (pressed_s[i]) begin
              state_q <= PRESSED;
              cnt_q   <= '0;
            end else if (cnt_q == DB) begin
              state_q <= RELEASED;
              lvl_q   <= 1'b0;
              rel_q   <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 24'd1;
            end
          end
          default: begin
            state_q <= RELEASED;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    assign kif.key_level[i]   = lvl_q;
    assign kif.key_press[i]   = prs_q;
    assign kif.key_release[i] = rel_q;
  end

endmodule
